regfile_wb: RTL and testbench
=============================

# regfile_wb

Write-back stage directly upstream of `regfile`: the sole driver of its write port (`regwrite`, `wa`, `wd`). It merges ALU results and returning load data onto that single port. Load returns pass through a small FIFO. A per-register scoreboard of outstanding loads is kept so decode can stall on operands still in flight.

## Interface
- `WIDTH`, 16, data width (matches `regfile`)
- `REGBITS`, 4, register address width; 2^REGBITS scoreboard bits
- `DEPTH`, 2, load-return FIFO entries (power of two, ≥2)

- `clk`  in  1  clock; all state updates on rising edge
- `reset`  in  1  asynchronous, active-low; clears all state immediately
- `alu_valid`  in  1  ALU result offered
- `alu_ready`  out  1  ALU result accepted this cycle when both high
- `alu_wa`  in  REGBITS  ALU destination
- `alu_wd`  in  WIDTH  ALU data
- `ld_issue`  in  1  load issued by decode; marks `ld_issue_wa` pending
- `ld_issue_wa`  in  REGBITS  load destination at issue
- `ld_valid`  in  1  load data returning
- `ld_ready`  out  1  FIFO can accept
- `ld_wa`  in  REGBITS  returning load destination
- `ld_wd`  in  WIDTH  returning load data
- `wb_hold`  in  1  suppress new write-port issue this cycle
- `ra1`, `ra2`  in  REGBITS  decode source addresses (same values sent to `regfile`)
- `pend1`, `pend2`  out  1  source register has an outstanding load
- `regwrite`  out  1  registered write enable to `regfile`
- `wa`  out  REGBITS  registered write address
- `wd`  out  WIDTH  registered write data
- `busy`  out  1  FIFO non-empty or any pending bit set
- `sb_err`  out  1  sticky: load issued to an already-pending register

## Operation
- Reset values: `regwrite`=0, `wa`=0, `wd`=0, FIFO empty, all pending bits 0, `sb_err`=0. Therefore `ld_ready`=1, `alu_ready`=1 unless `wb_hold`, `busy`=0.
- Load push: `ld_valid && ld_ready`. `ld_ready` = count < DEPTH. There is no pop-through when full.
- Issue select each cycle, only when `wb_hold`=0:
  - FIFO non-empty: pop the head to the write port.
  - FIFO empty and `alu_valid`: write the ALU result.
  - Otherwise: no write.
- `alu_ready` = !`wb_hold` && count==0. Loads always take priority over the ALU.
- Write port registers load from the selection: `regwrite` is high for exactly one cycle per write. `wa`/`wd` hold their last values when `regwrite`=0.
- Scoreboard:
  - `ld_issue` sets `pending[ld_issue_wa]`.
  - A load pop clears `pending[head wa]`.
  - Set and clear of the same register in the same cycle: set wins.
  - `ld_issue` to a register already pending (and not being cleared that cycle) sets `sb_err`. The bit stays 1.
- ALU writes never touch the scoreboard. Hazard ordering is decode's responsibility.
- `pend1`/`pend2` are combinational from the `ra1`/`ra2` lookups of the current pending bits.
- Register 0 is not special-cased.

## Timing
- ALU accepted at edge N: `regwrite`=1 in cycle N+1.
- Load pushed at edge N into an empty FIFO: pop at N+1, `regwrite`=1 in cycle N+2. `pend*` for that register drops in cycle N+2.
- `ld_issue` at edge N: `pend*` high from cycle N+1.
- `wb_hold` high: `regwrite`=0 next cycle. The FIFO keeps accepting until full. The ALU is stalled.
- Reset asserted mid-operation: FIFO contents and pending bits are discarded at once, and outputs go to reset values asynchronously.
- Deassertion is synchronised externally.

## Structure
- Shared package holds `WIDTH` and `REGBITS` defaults. The same package is used by `regfile`, decode and the ALU.
- One sub-module, `wb_load_fifo`: parameterised DEPTH×(REGBITS+WIDTH) FIFO with wrap-around pointers and an occupancy count, plus push/pop/full/empty.
- Arbiter, scoreboard and output registers live in `regfile_wb`.

## Test plan
- Reset: drive traffic, pull `reset` low mid-cycle. Required immediately: all outputs 0 except `ld_ready`=1 and `alu_ready`=1. Required after release: `busy`=0.
- ALU write: `alu_valid`, `alu_wa`=3, `alu_wd`=0x1234 at edge N. Required: `regwrite`=1, `wa`=3, `wd`=0x1234 in cycle N+1 only.
- Load round trip: `ld_issue_wa`=5, then `ra1`=5. Required: `pend1`=1. Then push `ld_wa`=5, `ld_wd`=0xBEEF at edge N. Required: write in cycle N+2 and `pend1`=0 in cycle N+2.
- Contention: FIFO holds 1 entry and `alu_valid`=1. Required: `alu_ready`=0, load written first, ALU written the following cycle.
- Full/hold: `wb_hold`=1, push loads to r1 and r2. Required: `ld_ready`=0 after 2 pushes. Release the hold. Required: writes in r1, r2 order and wrap-around pointers correct across 5 fill/drain rounds.
- Scoreboard edges: pop r7 in the same cycle as `ld_issue` r7. Required: r7 stays pending, `sb_err`=0. A second issue to r7 while pending. Required: `sb_err`=1, sticky until reset.

Source files
------------

// File: rtl/regfile_wb_pkg.sv
// Shared datapath defaults for regfile, decode, ALU and the write-back stage.
// Also carries the write-port source selection type.
package regfile_wb_pkg;

    localparam int WIDTH   = 16;
    localparam int REGBITS = 4;

    typedef enum logic [1:0] {
        SEL_NONE = 2'd0,
        SEL_LOAD = 2'd1,
        SEL_ALU  = 2'd2
    } wb_sel_e;

endpackage

// File: rtl/wb_load_fifo.sv
// Load-return FIFO: DEPTH entries of {wa, wd}, wrap-around pointers, occupancy count.
// Push is refused when full and pop when empty, so callers may drive them freely.
module wb_load_fifo #(
    parameter int DEPTH = 2,
    parameter int DW    = 20
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_push,
    input  logic [DW-1:0] i_data,
    input  logic          i_pop,
    output logic [DW-1:0] o_data,
    output logic          o_full,
    output logic          o_empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [DW-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          w_push;
    logic          w_pop;

    assign o_full  = (r_count == FULL_CNT);
    assign o_empty = (r_count == '0);
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_data  = r_mem[r_rd_ptr];

    // Power-of-two depth lets the pointers wrap by plain overflow.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_data;
    end

endmodule

// File: rtl/regfile_wb.sv
// Write-back stage: merges ALU results and load returns onto the regfile write port,
// and tracks outstanding loads per register so decode can stall on them.
module regfile_wb #(
    parameter int WIDTH   = regfile_wb_pkg::WIDTH,
    parameter int REGBITS = regfile_wb_pkg::REGBITS,
    parameter int DEPTH   = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               alu_valid,
    output logic               alu_ready,
    input  logic [REGBITS-1:0] alu_wa,
    input  logic [WIDTH-1:0]   alu_wd,
    input  logic               ld_issue,
    input  logic [REGBITS-1:0] ld_issue_wa,
    input  logic               ld_valid,
    output logic               ld_ready,
    input  logic [REGBITS-1:0] ld_wa,
    input  logic [WIDTH-1:0]   ld_wd,
    input  logic               wb_hold,
    input  logic [REGBITS-1:0] ra1,
    input  logic [REGBITS-1:0] ra2,
    output logic               pend1,
    output logic               pend2,
    output logic               regwrite,
    output logic [REGBITS-1:0] wa,
    output logic [WIDTH-1:0]   wd,
    output logic               busy,
    output logic               sb_err
);

    import regfile_wb_pkg::*;

    localparam int NREG = 1 << REGBITS;

    logic [NREG-1:0]          r_pending;
    logic [NREG-1:0]          w_pending_nxt;
    logic [REGBITS+WIDTH-1:0] w_head;
    logic [REGBITS-1:0]       w_head_wa;
    logic [WIDTH-1:0]         w_head_wd;
    logic                     w_fifo_full;
    logic                     w_fifo_empty;
    logic                     w_pop;
    logic                     w_issue_err;
    wb_sel_e                  w_sel;

    wb_load_fifo #(
        .DEPTH (DEPTH),
        .DW    (REGBITS + WIDTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (ld_valid),
        .i_data  ({ld_wa, ld_wd}),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    assign {w_head_wa, w_head_wd} = w_head;
    assign ld_ready  = !w_fifo_full;
    assign alu_ready = !wb_hold && w_fifo_empty;
    assign busy      = !w_fifo_empty || (|r_pending);
    assign pend1     = r_pending[ra1];
    assign pend2     = r_pending[ra2];

    // Queued loads always beat the ALU for the single write port.
    always_comb begin
        w_sel = SEL_NONE;
        if (!wb_hold) begin
            if (!w_fifo_empty)  w_sel = SEL_LOAD;
            else if (alu_valid) w_sel = SEL_ALU;
        end
    end

    assign w_pop = (w_sel == SEL_LOAD);

    // Set is applied after clear so a same-cycle issue to the popped register wins.
    always_comb begin
        w_pending_nxt = r_pending;
        if (w_pop)    w_pending_nxt[w_head_wa]   = 1'b0;
        if (ld_issue) w_pending_nxt[ld_issue_wa] = 1'b1;
    end

    assign w_issue_err = ld_issue && r_pending[ld_issue_wa] &&
                         !(w_pop && (w_head_wa == ld_issue_wa));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            regwrite  <= 1'b0;
            wa        <= '0;
            wd        <= '0;
            r_pending <= '0;
            sb_err    <= 1'b0;
        end else begin
            regwrite  <= (w_sel != SEL_NONE);
            r_pending <= w_pending_nxt;
            if (w_issue_err) sb_err <= 1'b1;
            case (w_sel)
                SEL_LOAD: begin
                    wa <= w_head_wa;
                    wd <= w_head_wd;
                end
                SEL_ALU: begin
                    wa <= alu_wa;
                    wd <= alu_wd;
                end
                default: begin
                    wa <= wa;
                    wd <= wd;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_wb.sv
// Scoreboard bench for regfile_wb: directed stimulus queues expected writes,
// a negedge monitor pops and compares every regfile write it observes.
module tb_regfile_wb;

    logic        clk;
    logic        reset;
    logic        alu_valid, alu_ready;
    logic [3:0]  alu_wa;
    logic [15:0] alu_wd;
    logic        ld_issue;
    logic [3:0]  ld_issue_wa;
    logic        ld_valid, ld_ready;
    logic [3:0]  ld_wa;
    logic [15:0] ld_wd;
    logic        wb_hold;
    logic [3:0]  ra1, ra2;
    logic        pend1, pend2;
    logic        regwrite;
    logic [3:0]  wa;
    logic [15:0] wd;
    logic        busy, sb_err;

    typedef struct {
        logic [3:0]  wa;
        logic [15:0] wd;
        int          cyc;
    } exp_t;

    exp_t q[$];
    int   cyc    = 0;
    int   npass  = 0;
    int   ntotal = 0;

    regfile_wb dut (
        .clk         (clk),
        .reset       (reset),
        .alu_valid   (alu_valid),
        .alu_ready   (alu_ready),
        .alu_wa      (alu_wa),
        .alu_wd      (alu_wd),
        .ld_issue    (ld_issue),
        .ld_issue_wa (ld_issue_wa),
        .ld_valid    (ld_valid),
        .ld_ready    (ld_ready),
        .ld_wa       (ld_wa),
        .ld_wd       (ld_wd),
        .wb_hold     (wb_hold),
        .ra1         (ra1),
        .ra2         (ra2),
        .pend1       (pend1),
        .pend2       (pend2),
        .regwrite    (regwrite),
        .wa          (wa),
        .wd          (wd),
        .busy        (busy),
        .sb_err      (sb_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        ntotal++;
        if (act === exp) npass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_write(input logic [3:0] a, input logic [15:0] d, input int c);
        exp_t e;
        e.wa = a; e.wd = d; e.cyc = c;
        q.push_back(e);
    endtask

    // Monitor: every observed write must match the oldest expectation.
    always @(negedge clk) begin
        if (reset && regwrite) begin
            if (q.size() == 0) begin
                chk("unexpected_write_wa", {28'd0, wa}, 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("write_wa",  {28'd0, wa}, {28'd0, e.wa});
                chk("write_wd",  {16'd0, wd}, {16'd0, e.wd});
                chk("write_cyc", cyc, e.cyc);
            end
        end
    end

    initial begin
        reset = 1'b0; alu_valid = 0; alu_wa = 0; alu_wd = 0;
        ld_issue = 0; ld_issue_wa = 0; ld_valid = 0; ld_wa = 0; ld_wd = 0;
        wb_hold = 0; ra1 = 0; ra2 = 0;
        repeat (2) tick();
        chk("rst_regwrite", {31'd0, regwrite}, 0);
        chk("rst_busy",     {31'd0, busy}, 0);
        chk("rst_ld_ready", {31'd0, ld_ready}, 1);
        chk("rst_alu_ready", {31'd0, alu_ready}, 1);
        reset = 1'b1;
        tick();

        // ALU write: one write cycle right after acceptance
        alu_valid = 1; alu_wa = 4'd3; alu_wd = 16'h1234;
        expect_write(4'd3, 16'h1234, cyc + 1);
        tick();
        alu_valid = 0;
        tick();
        chk("alu_single_cycle", {31'd0, regwrite}, 0);

        // Load round trip
        ld_issue = 1; ld_issue_wa = 4'd5;
        tick();
        ld_issue = 0; ra1 = 4'd5; ra2 = 4'd5;
        #1;
        chk("pend1_set", {31'd0, pend1}, 1);
        chk("pend2_set", {31'd0, pend2}, 1);
        chk("busy_pending", {31'd0, busy}, 1);
        ld_valid = 1; ld_wa = 4'd5; ld_wd = 16'hBEEF;
        expect_write(4'd5, 16'hBEEF, cyc + 2);
        tick();
        ld_valid = 0;
        chk("pend1_still", {31'd0, pend1}, 1);
        tick();
        chk("pend1_cleared", {31'd0, pend1}, 0);
        tick();
        chk("busy_idle", {31'd0, busy}, 0);

        // Contention: one queued load beats a waiting ALU result
        wb_hold = 1; ld_valid = 1; ld_wa = 4'd8; ld_wd = 16'h0808;
        tick();
        ld_valid = 0; wb_hold = 0;
        alu_valid = 1; alu_wa = 4'd10; alu_wd = 16'h0A0A;
        #1;
        chk("contend_alu_ready", {31'd0, alu_ready}, 0);
        expect_write(4'd8, 16'h0808, cyc + 1);
        expect_write(4'd10, 16'h0A0A, cyc + 2);
        tick();
        chk("contend_alu_ready_after", {31'd0, alu_ready}, 1);
        tick();
        alu_valid = 0;
        tick();

        // Full/hold with wrap-around across several rounds
        for (int r = 0; r < 5; r++) begin
            wb_hold = 1; ld_valid = 1;
            ld_wa = 4'd1; ld_wd = 16'hA000 + 16'(r * 2);
            tick();
            ld_wa = 4'd2; ld_wd = 16'hA001 + 16'(r * 2);
            tick();
            chk("full_ld_ready", {31'd0, ld_ready}, 0);
            chk("hold_alu_ready", {31'd0, alu_ready}, 0);
            ld_wa = 4'd3; ld_wd = 16'hDEAD;
            tick();
            ld_valid = 0; wb_hold = 0;
            expect_write(4'd1, 16'hA000 + 16'(r * 2), cyc + 1);
            expect_write(4'd2, 16'hA001 + 16'(r * 2), cyc + 2);
            tick();
            tick();
            chk("drained_ld_ready", {31'd0, ld_ready}, 1);
            tick();
        end

        // Scoreboard edges on r7
        ld_issue = 1; ld_issue_wa = 4'd7;
        tick();
        ld_issue = 0;
        ld_valid = 1; ld_wa = 4'd7; ld_wd = 16'h7777;
        expect_write(4'd7, 16'h7777, cyc + 2);
        tick();
        ld_valid = 0; ld_issue = 1; ld_issue_wa = 4'd7;
        tick();
        ld_issue = 0; ra1 = 4'd7;
        #1;
        chk("set_wins_pend", {31'd0, pend1}, 1);
        chk("set_wins_no_err", {31'd0, sb_err}, 0);
        ld_issue = 1; ld_issue_wa = 4'd7;
        tick();
        ld_issue = 0;
        chk("double_issue_err", {31'd0, sb_err}, 1);
        ld_valid = 1; ld_wa = 4'd7; ld_wd = 16'h7778;
        expect_write(4'd7, 16'h7778, cyc + 2);
        tick();
        ld_valid = 0;
        tick();
        chk("r7_cleared", {31'd0, pend1}, 0);
        tick();
        chk("sb_err_sticky", {31'd0, sb_err}, 1);

        // Reset mid-operation: write in flight, load queued, register pending
        alu_valid = 1; alu_wa = 4'd9; alu_wd = 16'h5555;
        ld_valid = 1; ld_wa = 4'd6; ld_wd = 16'h6666;
        ld_issue = 1; ld_issue_wa = 4'd6; ra2 = 4'd6;
        expect_write(4'd9, 16'h5555, cyc + 1);
        tick();
        alu_valid = 0; ld_valid = 0; ld_issue = 0;
        chk("pre_reset_busy", {31'd0, busy}, 1);
        @(negedge clk);
        #1;
        reset = 1'b0;
        #1;
        chk("arst_regwrite", {31'd0, regwrite}, 0);
        chk("arst_wa", {28'd0, wa}, 0);
        chk("arst_wd", {16'd0, wd}, 0);
        chk("arst_pend2", {31'd0, pend2}, 0);
        chk("arst_sb_err", {31'd0, sb_err}, 0);
        chk("arst_busy", {31'd0, busy}, 0);
        chk("arst_ld_ready", {31'd0, ld_ready}, 1);
        chk("arst_alu_ready", {31'd0, alu_ready}, 1);
        tick();
        reset = 1'b1;
        tick();
        chk("post_reset_busy", {31'd0, busy}, 0);
        chk("post_reset_regwrite", {31'd0, regwrite}, 0);

        for (int i = 0; i < 20 && q.size() != 0; i++) tick();
        chk("queue_drained", q.size(), 0);
        tick();
        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule
